coinc_trig_gen: RTL and testbench
=================================

# coinc_trig_gen

Parametrised N-of-M coincidence trigger generator for the RADIANT trigger path. It takes per-channel discriminator outputs, stretches each rising edge into a programmable coincidence window, and counts the channels open at the same time. When the count exceeds a programmable threshold, it fires a one-cycle trigger and then holds off. It sits between the trigger-input enable/mask stage and the overlord/event-readout logic, and generalises the fixed 24-channel single-window trigger with parametric channel count, a holdoff timer, a channel snapshot and a trigger counter.

## Interface
- NCHAN, 24, number of trigger channels
- WIN_BITS, 8, width of window_i
- HOLDOFF_BITS, 16, width of holdoff_i
- CNT_BITS, $clog2(NCHAN+1), width of threshold and count
- clk_i  in  1  trigger clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  1  trigger enable; 0 forces IDLE
- trig_i  in  NCHAN  discriminator inputs, already synchronous to clk_i
- mask_i  in  NCHAN  1 = channel participates
- window_i  in  WIN_BITS  coincidence window; stretch length = window_i+1 cycles
- thresh_i  in  CNT_BITS  fire when count > thresh_i (0 = single channel)
- holdoff_i  in  HOLDOFF_BITS  dead cycles after a fire
- trig_o  out  1  one-cycle trigger pulse
- trig_chans_o  out  NCHAN  channels open at the fire, held until the next fire
- count_o  out  CNT_BITS  current number of open channels
- busy_o  out  1  high during HOLDOFF
- ntrig_o  out  32  fires since reset, wraps

## Operation
- Edge detect: `edge[k] = trig_i[k] & ~prev[k] & mask_i[k]`, with `prev` registered every cycle. A level held high produces exactly one edge.
- Stretcher[k]: WIN_BITS+1 down-counter.
  - An edge in ARMED loads window_i+1.
  - Otherwise the counter decrements to 0.
  - `open[k] = (cnt != 0)`.
  - A re-edge while open reloads the counter; it does not accumulate.
- window_i is sampled at load only. thresh_i is compared live. Changing either never causes a spurious fire by itself unless the live condition holds.
- count = popcount(open).
- FSM:
  - IDLE: stretchers held at 0. IDLE->ARMED when en_i=1.
  - ARMED: when count > thresh_i, assert trig_o, latch trig_chans_o = open, increment ntrig_o, clear all stretchers, load the holdoff counter with holdoff_i, go to HOLDOFF.
  - HOLDOFF: edges ignored and stretchers held at 0. The counter decrements each cycle; leave when it reads 0. HOLDOFF lasts max(holdoff_i,1) cycles, then ARMED.
  - Any state with en_i=0: go to IDLE next cycle, clear stretchers, no fire.
- An edge arriving in the same cycle as a fire is dropped.
- Reset values: all outputs 0, FSM IDLE, stretchers 0, prev 0. Reset mid-window or mid-holdoff returns the block to IDLE without a fire.

## Timing
- trig_i rising edge sampled at edge N: open at N+1; trig_o high for the cycle after edge N+1. Latency is 2 clocks.
- count_o is registered and equals popcount(open) of the previous cycle.
- A channel edge at N is open for cycles N+1 .. N+window_i+1.
- Minimum trigger spacing: 2 + max(holdoff_i,1) cycles.
- trig_chans_o and ntrig_o update in the same cycle trig_o is high.

## Configuration
- COINC_TRIG_PIPE_EN defined: an extra register stage sits between popcount and the compare, for timing closure at large NCHAN.
  - Latency becomes 3 clocks.
  - The fire compare uses the pipelined count.
  - Stretchers clear on fire, and the next-cycle compare is suppressed to prevent a double fire.
- Undefined: latency is 2 clocks as above.
- Function, outputs and the holdoff length are otherwise identical in both builds.

## Test plan
- Coincidence: NCHAN=24, thresh=2, window=72, holdoff=10; single-cycle pulses on ch0/1/2 at cycles 0/10/20 -> trig_o=1 at cycle 22 only, trig_chans_o=0x000007, ntrig_o=1.
- Window expiry: same setup with the ch2 pulse at cycle 80 (ch0 closes after cycle 73) -> no trig_o, count_o peaks at 2.
- Holdoff: thresh=0, holdoff=10; ch5 pulses at 0, 5, 20 -> trig_o at 2 and 22 only, busy_o high for 10 cycles after each fire, ntrig_o=2.
- Mask/level: mask_i[3]=0 with a ch3 pulse -> no fire. ch4 held high for 500 cycles with thresh=0 -> exactly one fire.
- Enable/reset: en_i dropped while count_o=2 -> count_o=0 within 2 cycles, no fire. rst_i pulsed during HOLDOFF -> busy_o=0 and all outputs 0 next cycle.
- PIPE_EN build: rerun the coincidence scenario -> trig_o at cycle 23, single pulse.

Source files
------------

// File: rtl/coinc_trig_gen.sv
// coinc_trig_gen: N-of-M coincidence trigger with per-channel window
// stretchers, holdoff timer, channel snapshot and trigger counter.
// Optional define COINC_TRIG_PIPE_EN adds a register between popcount and compare.
module coinc_trig_gen #(
    parameter int NCHAN        = 24,
    parameter int WIN_BITS     = 8,
    parameter int HOLDOFF_BITS = 16,
    parameter int CNT_BITS     = $clog2(NCHAN+1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [NCHAN-1:0]        trig_i,
    input  logic [NCHAN-1:0]        mask_i,
    input  logic [WIN_BITS-1:0]     window_i,
    input  logic [CNT_BITS-1:0]     thresh_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    output logic                    trig_o,
    output logic [NCHAN-1:0]        trig_chans_o,
    output logic [CNT_BITS-1:0]     count_o,
    output logic                    busy_o,
    output logic [31:0]             ntrig_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_HOLDOFF
    } state_t;

    localparam logic [WIN_BITS:0]       WONE = 1;
    localparam logic [HOLDOFF_BITS-1:0] HONE = 1;

    state_t                  state_q, state_d;
    logic [NCHAN-1:0]        prev_q;
    logic [WIN_BITS:0]       str_q [NCHAN];
    logic [WIN_BITS:0]       str_d [NCHAN];
    logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
    logic [NCHAN-1:0]        edg;
    logic [NCHAN-1:0]        open_v;
    logic [CNT_BITS-1:0]     pop;
    logic                    fire;
    logic                    clr;
    logic                    trig_q;
    logic [NCHAN-1:0]        chans_q;
    logic [CNT_BITS-1:0]     count_q;
    logic [31:0]             ntrig_q;
    logic [WIN_BITS:0]       load_val;

    assign edg      = trig_i & ~prev_q & mask_i;
    assign load_val = {1'b0, window_i} + WONE;

    // Open flags and their popcount from the current stretcher state
    always_comb begin
        pop = '0;
        for (int k = 0; k < NCHAN; k++) begin
            open_v[k] = (str_q[k] != '0);
            pop       = pop + CNT_BITS'(open_v[k]);
        end
    end

`ifdef COINC_TRIG_PIPE_EN
    logic supp_q;

    // Compare against the registered count; blank the cycle after a fire
    assign fire = (state_q == S_ARMED) && en_i && !supp_q
                  && (count_q > thresh_i);

    // Suppression flag for the cycle following a fire
    always_ff @(posedge clk_i) begin
        if (rst_i) supp_q <= 1'b0;
        else       supp_q <= fire;
    end
`else
    // Compare against the live popcount
    assign fire = (state_q == S_ARMED) && en_i && (pop > thresh_i);
`endif

    assign clr = (state_q != S_ARMED) || !en_i || fire;

    // Stretcher next-state: clear, reload on edge, else count down
    always_comb begin
        for (int k = 0; k < NCHAN; k++) begin
            str_d[k] = str_q[k];
            if (clr)
                str_d[k] = '0;
            else if (edg[k])
                str_d[k] = load_val;
            else if (str_q[k] != '0)
                str_d[k] = str_q[k] - WONE;
        end
    end

    // FSM next-state and holdoff counter
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            S_IDLE: begin
                if (en_i) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                end else if (fire) begin
                    state_d = S_HOLDOFF;
                    hold_d  = (holdoff_i == '0) ? '0 : holdoff_i - HONE;
                end
            end
            S_HOLDOFF: begin
                if (!en_i)
                    state_d = S_IDLE;
                else if (hold_q == '0)
                    state_d = S_ARMED;
                else
                    hold_d = hold_q - HONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, stretcher and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            prev_q  <= '0;
            hold_q  <= '0;
            trig_q  <= 1'b0;
            chans_q <= '0;
            count_q <= '0;
            ntrig_q <= '0;
            for (int k = 0; k < NCHAN; k++) str_q[k] <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= trig_i;
            hold_q  <= hold_d;
            trig_q  <= fire;
            count_q <= pop;
            if (fire) begin
                chans_q <= open_v;
                ntrig_q <= ntrig_q + 32'd1;
            end
            for (int k = 0; k < NCHAN; k++) str_q[k] <= str_d[k];
        end
    end

    assign trig_o       = trig_q;
    assign trig_chans_o = chans_q;
    assign count_o      = count_q;
    assign busy_o       = (state_q == S_HOLDOFF);
    assign ntrig_o      = ntrig_q;

endmodule

// File: tb/tb_coinc_trig_gen.sv
// tb_coinc_trig_gen: directed scenarios for coinc_trig_gen
// with hand-computed cycle expectations.
module tb_coinc_trig_gen;

    localparam int NCHAN = 24;
    localparam int CB    = 5;
`ifdef COINC_TRIG_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst, en;
    logic [NCHAN-1:0]  trig, mask;
    logic [7:0]        window;
    logic [CB-1:0]     thresh;
    logic [15:0]       holdoff;
    logic              trig_o;
    logic [NCHAN-1:0]  chans_o;
    logic [CB-1:0]     count_o;
    logic              busy_o;
    logic [31:0]       ntrig_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    coinc_trig_gen #(
        .NCHAN(NCHAN), .WIN_BITS(8), .HOLDOFF_BITS(16), .CNT_BITS(CB)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .trig_i(trig), .mask_i(mask), .window_i(window),
        .thresh_i(thresh), .holdoff_i(holdoff),
        .trig_o(trig_o), .trig_chans_o(chans_o), .count_o(count_o),
        .busy_o(busy_o), .ntrig_o(ntrig_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prep(input int th, input int win, input int ho);
        rst = 1'b1; en = 1'b0; trig = '0; mask = '1;
        thresh = CB'(th); window = 8'(win); holdoff = 16'(ho);
        step();
        rst = 1'b0; en = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; trig = '0; mask = '1;
        thresh = '0; window = '0; holdoff = '0;
        repeat (2) step();
        checks++;
        if (trig_o !== 1'b0) begin errors++;
            $display("FAIL reset_trig: got %0h expected 0", trig_o); end
        checks++;
        if (chans_o !== '0) begin errors++;
            $display("FAIL reset_chans: got %0h expected 0", chans_o); end
        checks++;
        if (count_o !== '0) begin errors++;
            $display("FAIL reset_count: got %0h expected 0", count_o); end
        checks++;
        if (busy_o !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %0h expected 0", busy_o); end
        checks++;
        if (ntrig_o !== 32'd0) begin errors++;
            $display("FAIL reset_ntrig: got %0h expected 0", ntrig_o); end
    endtask

    task automatic test_coincidence();
        int nf = 0, fc = -1, c21 = -1;
        logic [NCHAN-1:0] ch = '0;
        prep(2, 72, 10);
        for (int c = 0; c < 60; c++) begin
            trig = (c == 0) ? 24'h1 : (c == 10) ? 24'h2 :
                   (c == 20) ? 24'h4 : 24'h0;
            step();
            if (c + 1 == 21) c21 = int'(count_o);
            if (trig_o === 1'b1) begin
                nf++; fc = c + 1; ch = chans_o;
            end
        end
        checks++;
        if (nf != 1) begin errors++;
            $display("FAIL coinc_nfires: got %0d expected 1", nf); end
        checks++;
        if (fc != 20 + LAT) begin errors++;
            $display("FAIL coinc_cycle: got %0d expected %0d", fc, 20 + LAT); end
        checks++;
        if (ch !== 24'h000007) begin errors++;
            $display("FAIL coinc_chans: got %0h expected 7", ch); end
        checks++;
        if (ntrig_o !== 32'd1) begin errors++;
            $display("FAIL coinc_ntrig: got %0d expected 1", ntrig_o); end
        checks++;
        if (c21 != 2) begin errors++;
            $display("FAIL coinc_count21: got %0d expected 2", c21); end
    endtask

    task automatic test_window_expiry();
        int nf = 0, mx = 0, c74 = -1, c75 = -1, c82 = -1;
        prep(2, 72, 10);
        for (int c = 0; c < 100; c++) begin
            trig = (c == 0) ? 24'h1 : (c == 10) ? 24'h2 :
                   (c == 80) ? 24'h4 : 24'h0;
            step();
            if (trig_o === 1'b1) nf++;
            if (int'(count_o) > mx) mx = int'(count_o);
            if (c + 1 == 74) c74 = int'(count_o);
            if (c + 1 == 75) c75 = int'(count_o);
            if (c + 1 == 82) c82 = int'(count_o);
        end
        checks++;
        if (nf != 0) begin errors++;
            $display("FAIL win_nfires: got %0d expected 0", nf); end
        checks++;
        if (mx != 2) begin errors++;
            $display("FAIL win_peak: got %0d expected 2", mx); end
        checks++;
        if (c74 != 2) begin errors++;
            $display("FAIL win_count74: got %0d expected 2", c74); end
        checks++;
        if (c75 != 1) begin errors++;
            $display("FAIL win_count75: got %0d expected 1", c75); end
        checks++;
        if (c82 != 2) begin errors++;
            $display("FAIL win_count82: got %0d expected 2", c82); end
    endtask

    task automatic test_holdoff();
        int nf = 0, f1 = -1, f2 = -1, nb = 0;
        logic b_last = 1'b0, b_after = 1'b1;
        prep(0, 72, 10);
        for (int c = 0; c < 40; c++) begin
            trig = (c == 0 || c == 5 || c == 20) ? 24'h20 : 24'h0;
            step();
            if (busy_o === 1'b1) nb++;
            if (c + 1 == LAT + 9)  b_last  = busy_o;
            if (c + 1 == LAT + 10) b_after = busy_o;
            if (trig_o === 1'b1) begin
                nf++;
                if (f1 < 0) f1 = c + 1; else f2 = c + 1;
            end
        end
        checks++;
        if (nf != 2) begin errors++;
            $display("FAIL hold_nfires: got %0d expected 2", nf); end
        checks++;
        if (f1 != LAT) begin errors++;
            $display("FAIL hold_fire1: got %0d expected %0d", f1, LAT); end
        checks++;
        if (f2 != 20 + LAT) begin errors++;
            $display("FAIL hold_fire2: got %0d expected %0d", f2, 20 + LAT); end
        checks++;
        if (nb != 20) begin errors++;
            $display("FAIL hold_busy_cycles: got %0d expected 20", nb); end
        checks++;
        if (b_last !== 1'b1 || b_after !== 1'b0) begin errors++;
            $display("FAIL hold_busy_edge: got %0b%0b expected 10", b_last, b_after); end
        checks++;
        if (ntrig_o !== 32'd2) begin errors++;
            $display("FAIL hold_ntrig: got %0d expected 2", ntrig_o); end
    endtask

    task automatic test_mask_level();
        int nm = 0, nl = 0;
        prep(0, 72, 10);
        mask = ~24'h8;
        for (int c = 0; c < 20; c++) begin
            trig = (c == 0) ? 24'h8 : 24'h0;
            step();
            if (trig_o === 1'b1) nm++;
        end
        checks++;
        if (nm != 0) begin errors++;
            $display("FAIL mask_nfires: got %0d expected 0", nm); end
        mask = '1;
        for (int c = 0; c < 510; c++) begin
            trig = (c < 500) ? 24'h10 : 24'h0;
            step();
            if (trig_o === 1'b1) nl++;
        end
        checks++;
        if (nl != 1) begin errors++;
            $display("FAIL level_nfires: got %0d expected 1", nl); end
        checks++;
        if (ntrig_o !== 32'd1) begin errors++;
            $display("FAIL level_ntrig: got %0d expected 1", ntrig_o); end
    endtask

    task automatic test_enable();
        int nf = 0, c10 = -1, c12 = -1;
        prep(2, 72, 10);
        for (int c = 0; c < 25; c++) begin
            trig = (c == 0) ? 24'h1 : (c == 1) ? 24'h2 :
                   (c == 10) ? 24'h4 : 24'h0;
            en = (c >= 10 && c < 15) ? 1'b0 : 1'b1;
            if (c == 10) c10 = int'(count_o);
            step();
            if (c + 1 == 12) c12 = int'(count_o);
            if (trig_o === 1'b1) nf++;
        end
        checks++;
        if (c10 != 2) begin errors++;
            $display("FAIL en_count_before: got %0d expected 2", c10); end
        checks++;
        if (c12 != 0) begin errors++;
            $display("FAIL en_count_after: got %0d expected 0", c12); end
        checks++;
        if (nf != 0) begin errors++;
            $display("FAIL en_nfires: got %0d expected 0", nf); end
    endtask

    task automatic test_reset_holdoff();
        logic bpre = 1'b0;
        prep(0, 72, 10);
        for (int c = 0; c <= LAT + 3; c++) begin
            trig = (c == 0) ? 24'h1 : 24'h0;
            if (c == LAT + 3) begin
                bpre = busy_o;
                rst = 1'b1;
            end
            step();
        end
        rst = 1'b0;
        checks++;
        if (bpre !== 1'b1) begin errors++;
            $display("FAIL rsth_busy_pre: got %0b expected 1", bpre); end
        checks++;
        if (busy_o !== 1'b0 || trig_o !== 1'b0) begin errors++;
            $display("FAIL rsth_busy_trig: got %0b%0b expected 00", busy_o, trig_o); end
        checks++;
        if (chans_o !== '0 || count_o !== '0) begin errors++;
            $display("FAIL rsth_chans_count: got %0h/%0h expected 0/0", chans_o, count_o); end
        checks++;
        if (ntrig_o !== 32'd0) begin errors++;
            $display("FAIL rsth_ntrig: got %0d expected 0", ntrig_o); end
    endtask

    initial begin
        test_reset();
        test_coincidence();
        test_window_expiry();
        test_holdoff();
        test_mask_level();
        test_enable();
        test_reset_holdoff();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
